// File: rtl/timer_pkg.sv
// Shared encodings and digit constants for the BCD countdown timer.
package timer_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: load, shift-in, decrement with borrow, increment with carry.
module bcd_digit
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               clearn,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               shift,
  input  logic [DIGIT_W-1:0] shift_in,
  input  logic               dec,
  input  logic               inc,
  input  logic [DIGIT_W-1:0] wrap_val,
  output logic [DIGIT_W-1:0] q,
  output logic               ripple
);

  always_ff @(posedge clk) begin
    if (!clearn) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= shift_in;
    end else if (dec) begin
      q <= (q == '0) ? wrap_val : q - 4'd1;
    end else if (inc) begin
      q <= (q >= wrap_val) ? '0 : q + 4'd1;
    end
  end

  // dec and inc are never requested together, so one ripple line serves both chains
  assign ripple = (dec && (q == '0)) || (inc && (q >= wrap_val));

endmodule

// File: rtl/bcd_countdown_timer.sv
// M:SS BCD countdown with keypad entry, pause/resume and +30 s quick-add.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned NUM_MIN_DIGITS = 1,
  parameter int unsigned TICK_DIV       = 1,
  parameter int unsigned ADD_TENS       = 3
) (
  input  logic                          CLK,
  input  logic                          clearn,
  input  logic [3:0]                    digit,
  input  logic                          digit_valid,
  input  logic                          loadn,
  input  logic                          enable,
  input  logic                          add30,
  output logic [4*NUM_MIN_DIGITS-1:0]   minutes,
  output logic [3:0]                    tens_secs,
  output logic [3:0]                    secs,
  output logic                          timer_done,
  output logic                          running
);

  localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [DIGIT_W:0] TENS_ADD = (DIGIT_W + 1)'(ADD_TENS);

  state_t state, state_nxt;
  logic [PS_W-1:0] ps;

  logic [DIGIT_W-1:0] min_q [NUM_MIN_DIGITS];
  logic [NUM_MIN_DIGITS-1:0] min_ripple;
  logic secs_ripple, tens_ripple;

  logic do_shift, in_count, do_add, active, tick;
  logic count_zero, count_one;
  logic [DIGIT_W:0] tens_sum;
  logic add_carry, saturate;
  logic [DIGIT_W-1:0] tens_added, tens_load_val;

  assign do_shift = (state == ST_IDLE) && !loadn && digit_valid && (digit <= BCD_MAX);
  assign in_count = loadn && ((state == ST_RUN) || (state == ST_PAUSE));
  assign do_add   = in_count && add30;
  assign active   = in_count && enable;
  // A quick-add freezes the prescaler, pushing a coincident tick out by one cycle
  assign tick     = active && !add30 && (ps == PS_LAST);

  assign count_zero = (minutes == '0) && (tens_secs == '0) && (secs == '0);
  assign count_one  = (minutes == '0) && (tens_secs == '0) && (secs == 4'd1);

  assign tens_sum      = {1'b0, tens_secs} + TENS_ADD;
  assign add_carry     = do_add && (tens_sum >= 5'd6);
  assign tens_added    = add_carry ? 4'(tens_sum - 5'd6) : tens_sum[DIGIT_W-1:0];
  assign saturate      = do_add && min_ripple[NUM_MIN_DIGITS-1];
  assign tens_load_val = saturate ? TENS_MAX : tens_added;

  bcd_digit u_secs (
    .clk      (CLK),
    .clearn   (clearn),
    .load     (saturate),
    .load_val (BCD_MAX),
    .shift    (do_shift),
    .shift_in (digit),
    .dec      (tick),
    .inc      (1'b0),
    .wrap_val (BCD_MAX),
    .q        (secs),
    .ripple   (secs_ripple)
  );

  bcd_digit u_tens (
    .clk      (CLK),
    .clearn   (clearn),
    .load     (do_add),
    .load_val (tens_load_val),
    .shift    (do_shift),
    .shift_in (secs),
    .dec      (secs_ripple),
    .inc      (1'b0),
    .wrap_val (TENS_MAX),
    .q        (tens_secs),
    .ripple   (tens_ripple)
  );

  for (genvar gi = 0; gi < NUM_MIN_DIGITS; gi++) begin : g_min
    logic [DIGIT_W-1:0] shift_src;
    logic               dec_req, inc_req;

    if (gi == 0) begin : g_lsd
      assign shift_src = tens_secs;
      assign dec_req   = tens_ripple;
      assign inc_req   = add_carry;
    end else begin : g_upper
      assign shift_src = min_q[gi-1];
      assign dec_req   = tick && min_ripple[gi-1];
      assign inc_req   = do_add && min_ripple[gi-1];
    end

    bcd_digit u_min (
      .clk      (CLK),
      .clearn   (clearn),
      .load     (saturate),
      .load_val (BCD_MAX),
      .shift    (do_shift),
      .shift_in (shift_src),
      .dec      (dec_req),
      .inc      (inc_req),
      .wrap_val (BCD_MAX),
      .q        (min_q[gi]),
      .ripple   (min_ripple[gi])
    );

    assign minutes[gi*DIGIT_W +: DIGIT_W] = min_q[gi];
  end

  always_comb begin
    state_nxt = state;
    if (!loadn) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) state_nxt = count_zero ? ST_DONE : ST_RUN;
        end
        ST_RUN, ST_PAUSE: begin
          if (tick && count_one) state_nxt = ST_DONE;
          else if (enable)       state_nxt = ST_RUN;
          else                   state_nxt = ST_PAUSE;
        end
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!clearn) begin
      state      <= ST_IDLE;
      timer_done <= 1'b0;
      running    <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer_done <= (state_nxt == ST_DONE);
      running    <= (state_nxt == ST_RUN);
    end
  end

  // Prescaler survives PAUSE so a resumed second is not restarted
  always_ff @(posedge CLK) begin
    if (!clearn || !in_count) begin
      ps <= '0;
    end else if (active && !add30) begin
      ps <= (ps == PS_LAST) ? '0 : ps + PS_W'(1);
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with a per-cycle digit-level reference model.
module tb_bcd_countdown_timer;

  localparam int unsigned N  = 1;
  localparam int unsigned TD = 4;
  localparam int unsigned AT = 3;

  localparam int MI = 0;
  localparam int MR = 1;
  localparam int MP = 2;
  localparam int MD = 3;

  logic CLK = 1'b0;
  logic clearn, digit_valid, loadn, enable, add30;
  logic [3:0] digit;
  logic [4*N-1:0] minutes;
  logic [3:0] tens_secs, secs;
  logic timer_done, running;

  int passed = 0;
  int total  = 0;

  int m_min, m_tens, m_secs, m_ps, m_mode;
  bit model_on = 1'b0;

  bcd_countdown_timer #(
    .NUM_MIN_DIGITS (N),
    .TICK_DIV       (TD),
    .ADD_TENS       (AT)
  ) dut (
    .CLK         (CLK),
    .clearn      (clearn),
    .digit       (digit),
    .digit_valid (digit_valid),
    .loadn       (loadn),
    .enable      (enable),
    .add30       (add30),
    .minutes     (minutes),
    .tens_secs   (tens_secs),
    .secs        (secs),
    .timer_done  (timer_done),
    .running     (running)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [4*N-1:0] min_bcd(input int v);
    logic [4*N-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N); i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  function automatic logic [31:0] cnt();
    return 32'({minutes, tens_secs, secs});
  endfunction

  // Minutes are kept as a plain integer; seconds as two loose digits so
  // non-normalised entries like 1:79 count down exactly as keyed.
  task automatic model_step();
    int max_min;
    max_min = (10 ** N) - 1;
    if (!clearn) begin
      m_min = 0; m_tens = 0; m_secs = 0; m_ps = 0; m_mode = MI;
      model_on = 1'b1;
    end else if (!loadn) begin
      if (m_mode == MI && digit_valid && digit <= 4'd9) begin
        m_min  = (m_min * 10 + m_tens) % (10 ** N);
        m_tens = m_secs;
        m_secs = int'(digit);
      end
      m_mode = MI;
      m_ps   = 0;
    end else begin
      case (m_mode)
        MI: if (enable) m_mode = (m_min == 0 && m_tens == 0 && m_secs == 0) ? MD : MR;
        MR, MP: begin
          if (add30) begin
            m_tens += AT;
            if (m_tens >= 6) begin
              m_tens -= 6;
              m_min++;
              if (m_min > max_min) begin
                m_min = max_min; m_tens = 5; m_secs = 9;
              end
            end
          end else if (enable) begin
            if (m_ps == TD - 1) begin
              m_ps = 0;
              if (m_secs > 0) m_secs--;
              else if (m_tens > 0) begin m_tens--; m_secs = 9; end
              else begin m_min--; m_tens = 5; m_secs = 9; end
            end else begin
              m_ps++;
            end
          end
          if (enable) m_mode = (m_min == 0 && m_tens == 0 && m_secs == 0) ? MD : MR;
          else        m_mode = MP;
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge CLK) begin
    model_step();
    #1;
    if (model_on)
      chk("cycle", 32'({minutes, tens_secs, secs, timer_done, running}),
          32'({min_bcd(m_min), 4'(m_tens), 4'(m_secs), (m_mode == MD), (m_mode == MR)}));
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic key(input int d);
    digit = 4'(d);
    digit_valid = 1'b1;
    step(1);
    digit_valid = 1'b0;
  endtask

  task automatic load3(input int a, input int b, input int c);
    key(a); key(b); key(c);
  endtask

  task automatic pulse_add();
    add30 = 1'b1;
    step(1);
    add30 = 1'b0;
  endtask

  task automatic wait_done(input int max, output int k);
    k = 0;
    while (!timer_done && k <= max) begin
      step(1);
      k++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    clearn = 1'b0; loadn = 1'b0; enable = 1'b0;
    digit_valid = 1'b0; digit = '0; add30 = 1'b0;
    step(2);
    chk("reset_count", cnt(), 32'h000);
    chk("reset_done", 32'(timer_done), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
    clearn = 1'b1;

    // 1:79 entered as a non-normalised 139 s count
    key(2); key(1); key(7); key(9);
    chk("t1_load", cnt(), 32'h179);
    loadn = 1'b1; enable = 1'b1;
    step(1);
    chk("t1_running", 32'(running), 32'd1);
    step(3);
    chk("t1_hold", cnt(), 32'h179);
    step(1);
    chk("t1_first_tick", cnt(), 32'h178);
    wait_done(600, k);
    chk("t1_done_latency", 32'(k + 4), 32'd556);
    chk("t1_done_count", cnt(), 32'h000);
    chk("t1_done_running", 32'(running), 32'd0);

    loadn = 1'b0;
    step(1);
    chk("t2_done_clear", 32'(timer_done), 32'd0);
    load3(0, 0, 5);
    chk("t2_load", cnt(), 32'h005);
    loadn = 1'b1; enable = 1'b1;
    step(1);
    wait_done(40, k);
    chk("t2_done_latency", 32'(k), 32'd20);
    step(3);
    chk("t2_done_held", 32'(timer_done), 32'd1);
    loadn = 1'b0;
    step(1);
    chk("t2_idle_done", 32'(timer_done), 32'd0);
    chk("t2_idle_running", 32'(running), 32'd0);

    load3(0, 1, 0);
    loadn = 1'b1; enable = 1'b1;
    step(6);
    chk("t3_before_pause", cnt(), 32'h009);
    enable = 1'b0;
    step(10);
    chk("t3_paused", cnt(), 32'h009);
    chk("t3_paused_running", 32'(running), 32'd0);
    enable = 1'b1;
    step(2);
    chk("t3_resume_hold", cnt(), 32'h009);
    step(1);
    chk("t3_resume_tick", cnt(), 32'h008);

    loadn = 1'b0; step(1);
    load3(0, 4, 5);
    loadn = 1'b1; enable = 1'b1; step(1);
    enable = 1'b0; step(1);
    pulse_add();
    chk("t4_add_045", cnt(), 32'h115);

    loadn = 1'b0; step(1);
    load3(9, 4, 5);
    loadn = 1'b1; enable = 1'b1; step(1);
    enable = 1'b0; step(1);
    pulse_add();
    chk("t4_saturate", cnt(), 32'h959);

    loadn = 1'b0; step(1);
    load3(0, 4, 0);
    loadn = 1'b1; enable = 1'b1; step(1);
    step(3);
    chk("t4_pre_add", cnt(), 32'h040);
    pulse_add();
    chk("t4_add_on_tick", cnt(), 32'h110);
    step(1);
    chk("t4_deferred_tick", cnt(), 32'h109);

    loadn = 1'b0; step(1);
    load3(3, 2, 1);
    loadn = 1'b1; enable = 1'b1; step(1);
    chk("t5_run_321", cnt(), 32'h321);
    step(2);
    clearn = 1'b0;
    step(1);
    chk("t5_clear_count", cnt(), 32'h000);
    chk("t5_clear_running", 32'(running), 32'd0);
    clearn = 1'b1;

    step(1);
    chk("t6_zero_done", 32'(timer_done), 32'd1);
    loadn = 1'b0; enable = 1'b0; step(1);
    key(12);
    chk("t6_bad_digit_zero", cnt(), 32'h000);
    load3(1, 2, 3);
    key(12);
    chk("t6_bad_digit_123", cnt(), 32'h123);
    loadn = 1'b1;
    key(7);
    chk("t6_digit_in_run_mode", cnt(), 32'h123);
    pulse_add();
    chk("t6_add_in_idle", cnt(), 32'h123);
    enable = 1'b1; step(1);
    chk("t6_start", 32'(running), 32'd1);
    step(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Parametrised successor to the microwave keypad timer. Holds an M:SS BCD countdown with a configurable number of minute digits. Digits are shifted in from the keypad, and the count runs down once per prescaled second. Adds pause/resume, a +30 s quick-add, a qualified digit strobe and a clean done flag; sits between the keypad decoder and the display/magnetron controller.

Parameters:
NUM_MIN_DIGITS, 1, number of BCD minute digits (1..4).
TICK_DIV, 1, CLK cycles per counted second (≥1); 1 = one decrement per enabled cycle.
ADD_TENS, 3, tens-of-seconds added by add30 (3 = +30 s).

Ports:
CLK  in  1  system clock, all logic on rising edge.
clearn  in  1  synchronous active-low reset.
digit  in  4  BCD keypad digit.
digit_valid  in  1  one-cycle strobe qualifying digit.
loadn  in  1  0 = entry mode, 1 = run mode.
enable  in  1  1 = count (run), 0 = pause.
add30  in  1  one-cycle quick-add request.
minutes  out  4*NUM_MIN_DIGITS  minute digits, MSD at top nibble.
tens_secs  out  4  tens-of-seconds digit.
secs  out  4  seconds digit.
timer_done  out  1  count reached zero.
running  out  1  high in RUN state.

Behaviour:
- One clock (CLK); reset is synchronous and active-low (clearn). clearn=0 at an edge: all digits 0, prescaler 0, state IDLE, timer_done=0, running=0. Applies mid-run.
- States: IDLE, RUN, PAUSE, DONE. All outputs registered.
- loadn=0 in any state → IDLE next edge. Count is retained so entry can continue. timer_done clears.
- IDLE, loadn=0, digit_valid=1, digit≤9: shift left one nibble. secs←digit, tens_secs←secs, minutes LSD←tens_secs, minute MSD discarded. digit>9 ignored. digit_valid ignored when loadn=1.
- IDLE, loadn=1, enable=1: → RUN if count≠0, else → DONE. Prescaler cleared on entry.
- RUN: prescaler counts 0..TICK_DIV-1. Tick is the cycle it equals TICK_DIV-1, then it wraps to 0.
- Tick decrement: if secs>0, secs−1. Else if tens_secs>0, tens−1 and secs=9. Else borrow from minutes (BCD borrow across minute digits), tens=5, secs=9.
- If the tick result is 0:00, go to DONE on the same edge. timer_done=1 from that edge.
- Loaded tens_secs may be 6..9 (non-normalised, e.g. 1:79 = 139 s). It is counted as-is, never normalised on load.
- RUN, enable=0 → PAUSE. Prescaler and count hold. PAUSE, enable=1 → RUN with prescaler resumed, not cleared.
- add30 in RUN or PAUSE: tens += ADD_TENS. If result ≥6, subtract 6 and carry +1 minute with BCD ripple. Overflow out of the minute MSD saturates to all minutes 9, tens 5, secs 9.
- add30 in IDLE or DONE: ignored.
- add30 and tick in the same cycle: add applied, prescaler holds for that cycle, so the tick is deferred by exactly one cycle.
- DONE: count stays 0:00, timer_done=1, running=0. Leaves only via loadn=0 or clearn=0.

Decomposition:
- timer_pkg holds: state encoding (IDLE/RUN/PAUSE/DONE), BCD_MAX=9, TENS_MAX=5, digit width 4.
- One sub-module, bcd_digit: 4-bit BCD register with load, shift-in, decrement-with-borrow and increment-with-carry. Its wrap value is a port.
- Top instantiates NUM_MIN_DIGITS+2 bcd_digit copies plus FSM and prescaler.

Test Plan:
1. NUM_MIN_DIGITS=1, TICK_DIV=4. Shift 2,1,7,9 → minutes=1, tens=7, secs=9. Set loadn=1, enable=1 → first change to 1:78 after 4 cycles. timer_done rises exactly 139×4 cycles after RUN entry.
2. Load 0,5, then run → 0:04,0:03,... each 4 cycles. timer_done=1 at cycle 20 and held. loadn=0 → timer_done=0, state IDLE next edge.
3. Run from 0:10, drop enable after 6 cycles (0:09, prescaler=1), hold 10 cycles → no change. Re-enable → 0:08 exactly 3 cycles later.
4. add30 at 0:45 → 1:15. add30 at 9:45 → saturate 9:59. add30 coincident with a tick at 0:40 → 1:10 that edge, 1:09 one cycle later than nominal.
5. clearn=0 for one cycle during RUN at 3:21 → next edge all zeros, running=0, state IDLE.
6. Load nothing (0:00), loadn=1, enable=1 → timer_done=1 next edge. digit=12 with digit_valid in IDLE → count unchanged.
